// File: rtl/ula_serial_ctrl.sv
// Bit-serial ALU controller: one 1-bit slice per cycle, LSB first; result after WIDTH RUN cycles.
// One op in flight; start is ignored outside IDLE, back-to-back issue every WIDTH+2 cycles.
module ula_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             ainv_q, binv_q, addsub_q, slt_q;
  logic [1:0]       op_q;

  logic             ainv_d, binv_d, addsub_d, slt_d;
  logic [1:0]       op_d;
  logic             a_bit, b_bit, s_sum, s_cout, s_out;
  logic             last, ovf_int, slt_set;
  logic [WIDTH-1:0] res_next;

  // Unlisted codes fall through to plain AND with no overflow reporting.
  always_comb begin
    ainv_d   = 1'b0;
    binv_d   = 1'b0;
    addsub_d = 1'b0;
    slt_d    = 1'b0;
    op_d     = 2'b00;
    case (alu_ctl)
      4'b0000: op_d = 2'b00;
      4'b0001: op_d = 2'b01;
      4'b0010: begin op_d = 2'b10; addsub_d = 1'b1; end
      4'b0110: begin op_d = 2'b10; binv_d = 1'b1; addsub_d = 1'b1; end
      4'b0111: begin op_d = 2'b11; binv_d = 1'b1; slt_d = 1'b1; end
      4'b1100: begin op_d = 2'b00; ainv_d = 1'b1; binv_d = 1'b1; end
      default: op_d = 2'b00;
    endcase
  end

  always_comb begin
    a_bit  = a_sh[0] ^ ainv_q;
    b_bit  = b_sh[0] ^ binv_q;
    s_sum  = a_bit ^ b_bit ^ carry;
    s_cout = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
    case (op_q)
      2'b00:   s_out = a_bit & b_bit;
      2'b01:   s_out = a_bit | b_bit;
      2'b10:   s_out = s_sum;
      default: s_out = 1'b0;
    endcase
    last     = (state == RUN) && (cnt == CW'(WIDTH - 1));
    ovf_int  = carry ^ s_cout;
    slt_set  = s_sum ^ ovf_int;
    res_next = {s_out, res_sh};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      ainv_q   <= 1'b0;
      binv_q   <= 1'b0;
      addsub_q <= 1'b0;
      slt_q    <= 1'b0;
      op_q     <= 2'b00;
      result   <= '0;
      zero     <= 1'b1;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh     <= a;
          b_sh     <= b;
          cnt      <= '0;
          carry    <= binv_d;
          ainv_q   <= ainv_d;
          binv_q   <= binv_d;
          addsub_q <= addsub_d;
          slt_q    <= slt_d;
          op_q     <= op_d;
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next[WIDTH-1:1];
          carry  <= s_cout;
          cnt    <= cnt + 1'b1;
          if (last) begin
            result   <= slt_q ? WIDTH'(slt_set) : res_next;
            zero     <= slt_q ? ~slt_set : (res_next == '0);
            cout     <= s_cout;
            overflow <= addsub_q & ovf_int;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_serial_ctrl.sv
// Scoreboard bench for ula_serial_ctrl (WIDTH=8): expected results queued at issue, checked at done.
module tb_ula_serial_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a, b;
  logic [3:0] alu_ctl;
  logic       busy, done, zero, cout, overflow;
  logic [7:0] result;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       v;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] held;
  int         n_tests = 0;
  int         n_fail  = 0;

  ula_serial_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .alu_ctl(alu_ctl),
    .busy(busy), .done(done), .result(result), .zero(zero), .cout(cout),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] ctl, input logic [7:0] x, input logic [7:0] y);
    exp_t       e;
    logic       ai, bi;
    logic [8:0] s;
    ai  = (ctl == 4'b1100);
    bi  = (ctl == 4'b0110) || (ctl == 4'b0111) || (ctl == 4'b1100);
    s   = {1'b0, x ^ {8{ai}}} + {1'b0, y ^ {8{bi}}} + {8'd0, bi};
    e.c = s[8];
    e.v = 1'b0;
    case (ctl)
      4'b0001: e.r = x | y;
      4'b0010: begin e.r = s[7:0]; e.v = (x[7] == y[7]) && (e.r[7] != x[7]); end
      4'b0110: begin e.r = s[7:0]; e.v = (x[7] != y[7]) && (e.r[7] != x[7]); end
      4'b0111: e.r = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
      4'b1100: e.r = ~(x | y);
      default: e.r = x & y;
    endcase
    e.z = (e.r == 8'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",   {24'd0, result},   {24'd0, e.r});
        check("zero",     {31'd0, zero},     {31'd0, e.z});
        check("cout",     {31'd0, cout},     {31'd0, e.c});
        check("overflow", {31'd0, overflow}, {31'd0, e.v});
      end
    end
  end

  // Must be entered at a negedge; issues one op and waits for its done cycle.
  task automatic do_op(input logic [3:0] ctl, input logic [7:0] x, input logic [7:0] y,
                       input bit repulse);
    int n;
    bit found;
    while (busy || done) @(negedge clk);
    sb.push_back(model(ctl, x, y));
    start   = 1'b1;
    a       = x;
    b       = y;
    alu_ctl = ctl;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    found = 0;
    n     = 99;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("busy_run", {31'd0, busy}, 32'd1);
        check("result_held", {24'd0, result}, {24'd0, held});
      end
      if (repulse && i == 3) begin
        start   = 1'b1;
        a       = 8'h00;
        b       = 8'h00;
        alu_ctl = 4'b0010;
      end
      if (repulse && i == 4) start = 1'b0;
      if (done) begin
        found = 1;
        n     = i;
      end
    end
    check("latency", n, 32'd9);
    held = model(ctl, x, y).r;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    a       = 8'h00;
    b       = 8'h00;
    alu_ctl = 4'b0000;
    held    = 8'h00;
    #3;
    check("rst_busy",   {31'd0, busy},     32'd0);
    check("rst_done",   {31'd0, done},     32'd0);
    check("rst_result", {24'd0, result},   32'd0);
    check("rst_zero",   {31'd0, zero},     32'd1);
    check("rst_cout",   {31'd0, cout},     32'd0);
    check("rst_ovf",    {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_op(4'b0010, 8'h7F, 8'h01, 0);
    do_op(4'b0110, 8'h05, 8'h05, 0);
    do_op(4'b0111, 8'h80, 8'h01, 0);
    do_op(4'b0111, 8'h7F, 8'h80, 0);
    do_op(4'b1100, 8'hF0, 8'h0F, 0);
    do_op(4'b0001, 8'hF0, 8'h0F, 0);
    do_op(4'b0010, 8'hFF, 8'h01, 1);
    do_op(4'b1111, 8'h7F, 8'h01, 0);
    do_op(4'b0000, 8'hCA, 8'h5F, 0);
    do_op(4'b0110, 8'h80, 8'h01, 0);
    do_op(4'b0001, 8'h3C, 8'hC3, 0);

    // Abort an ADD mid-operation; the previous OR left result=0xFF.
    while (busy || done) @(negedge clk);
    start   = 1'b1;
    a       = 8'h11;
    b       = 8'h22;
    alu_ctl = 4'b0010;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy",   {31'd0, busy},     32'd0);
    check("abort_done",   {31'd0, done},     32'd0);
    check("abort_result", {24'd0, result},   32'd0);
    check("abort_zero",   {31'd0, zero},     32'd1);
    check("abort_cout",   {31'd0, cout},     32'd0);
    @(negedge clk);
    reset = 1'b0;
    held  = 8'h00;
    do_op(4'b0010, 8'h01, 8'h02, 0);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
